// File: rtl/alu_pkg.sv
// Shared definitions for the ALU port: control codes, flag layout and the
// sequencer FSM state encoding.
`timescale 1ns/1ps
package alu_pkg;

  // ALU control codes
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_XOR = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Flag vector layout: {ovf, carry, sign, zero}
  localparam int FLAG_W = 4;
  localparam int FLG_Z  = 0;
  localparam int FLG_S  = 1;
  localparam int FLG_C  = 2;
  localparam int FLG_V  = 3;

  // Sequencer FSM encoding
  localparam int         STATE_W   = 2;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

endpackage

// File: rtl/alu_op_sequencer.sv
// Initiator side of the combinational ALU port. Registers an accepted
// operation onto alu_*, waits SETTLE_CYCLES edges, samples result and flags
// into a response register and the architectural flag register.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The request side may drop or change req_* freely while
// req_ready is low; the response side holds rsp_result/rsp_flags stable from
// rsp_valid rising until the edge where rsp_ready is seen high. req_ready in
// RESP follows rsp_ready so a new request can be taken on the same edge the
// current response is consumed.
`timescale 1ns/1ps
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int CTRL_W        = 3,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [CTRL_W-1:0]   req_ctrl,
  input  logic [DATA_W-1:0]   req_a,
  input  logic [DATA_W-1:0]   req_b,
  output logic [CTRL_W-1:0]   alu_ctrl,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  input  logic [DATA_W-1:0]   alu_out,
  input  logic                alu_zero,
  input  logic                alu_sign,
  input  logic                alu_carry,
  input  logic                alu_ovf,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_result,
  output logic [FLAG_W-1:0]   rsp_flags,
  output logic [FLAG_W-1:0]   flags_q,
  output logic                busy,
  output logic [STATE_W-1:0]  dbg_state
);

  localparam int               CNT_W    = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  logic [STATE_W-1:0] state;
  logic [CNT_W-1:0]   cnt;
  logic               accept;

  // Request acceptance: idle, or consuming the current response this edge
  always_comb begin
    req_ready = 1'b0;
    if (rst_n) begin
      case (state)
        ST_IDLE: req_ready = 1'b1;
        ST_RESP: req_ready = rsp_ready;
        default: req_ready = 1'b0;
      endcase
    end
  end

  assign accept    = req_valid && req_ready;
  assign busy      = (state != ST_IDLE);
  assign dbg_state = state;

  // FSM, operand registers, settle counter and sampled response
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      alu_ctrl   <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      flags_q    <= '0;
    end else begin
      if (accept) begin
        alu_ctrl <= req_ctrl;
        alu_a    <= req_a;
        alu_b    <= req_b;
        cnt      <= CNT_LOAD;
      end
      case (state)
        ST_IDLE: begin
          if (accept) state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            rsp_result <= alu_out;
            rsp_flags  <= {alu_ovf, alu_carry, alu_sign, alu_zero};
            flags_q    <= {alu_ovf, alu_carry, alu_sign, alu_zero};
            rsp_valid  <= 1'b1;
            state      <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (accept) begin
            rsp_valid <= 1'b0;
            state     <= ST_SETTLE;
          end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: two instances (settle 1 and 3), each with a
// behavioural ALU responder behind alu_*.
`timescale 1ns/1ps
module tb_alu_op_sequencer;
  import alu_pkg::*;

  logic        clk, rst_n;
  logic        req_valid[2], req_ready[2];
  logic [2:0]  req_ctrl[2];
  logic [31:0] req_a[2], req_b[2];
  logic [2:0]  alu_ctrl[2];
  logic [31:0] alu_a[2], alu_b[2], alu_out[2];
  logic        alu_zero[2], alu_sign[2], alu_carry[2], alu_ovf[2];
  logic        rsp_valid[2], rsp_ready[2];
  logic [31:0] rsp_result[2];
  logic [3:0]  rsp_flags[2], flags_q[2];
  logic        busy[2];
  logic [1:0]  dbg_state[2];
  logic        glitch[2];
  logic [31:0] glitch_val;

  int total, bad;
  logic [35:0] exp_q[$];

  typedef struct {
    logic [2:0]  ctrl;
    logic [31:0] a, b, res;
    logic [3:0]  fl;
  } vec_t;
  vec_t tbl[9];

  // ALU behaviour: returns {ovf, carry, sign, zero, result}
  function automatic logic [35:0] alu_ref(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] w;
    logic [31:0] r;
    logic cy, v;
    cy = 1'b0; v = 1'b0; w = '0; r = '0;
    case (c)
      ALU_ADD: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; cy = w[32];
                     v = (a[31] == b[31]) && (r[31] != a[31]); end
      ALU_SUB: begin r = a - b; cy = (a < b); v = (a[31] != b[31]) && (r[31] != a[31]); end
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_SLL: r = a << b[4:0];
      ALU_SRL: r = a >> b[4:0];
      ALU_XOR: r = a ^ b;
      default: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
    return {v, cy, r[31], (r == 32'd0), r};
  endfunction

  function automatic int settle_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [35:0] r;
    assign r = alu_ref(alu_ctrl[g], alu_a[g], alu_b[g]);
    assign alu_out[g] = glitch[g] ? glitch_val : r[31:0];
    assign {alu_ovf[g], alu_carry[g], alu_sign[g], alu_zero[g]} = r[35:32];

    alu_op_sequencer #(.DATA_W(32), .CTRL_W(3), .SETTLE_CYCLES((g == 0) ? 1 : 3)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]), .req_ctrl(req_ctrl[g]),
      .req_a(req_a[g]), .req_b(req_b[g]),
      .alu_ctrl(alu_ctrl[g]), .alu_a(alu_a[g]), .alu_b(alu_b[g]),
      .alu_out(alu_out[g]), .alu_zero(alu_zero[g]), .alu_sign(alu_sign[g]),
      .alu_carry(alu_carry[g]), .alu_ovf(alu_ovf[g]),
      .rsp_valid(rsp_valid[g]), .rsp_ready(rsp_ready[g]),
      .rsp_result(rsp_result[g]), .rsp_flags(rsp_flags[g]), .flags_q(flags_q[g]),
      .busy(busy[g]), .dbg_state(dbg_state[g])
    );
  end

  // Driver / checker tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic issue(input int i, input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    int n;
    req_valid[i] = 1'b1; req_ctrl[i] = c; req_a[i] = a; req_b[i] = b;
    #1;
    n = 0;
    while (!req_ready[i] && n < 30) begin tick(); n++; end
    if (!req_ready[i]) chk("accept_timeout", 64'(req_ready[i]), 64'd1);
    tick();
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(input int i, output int lat);
    lat = 0;
    while (!rsp_valid[i] && lat < 20) begin tick(); lat++; end
  endtask

  task automatic take(input int i);
    rsp_ready[i] = 1'b1;
    tick();
    rsp_ready[i] = 1'b0;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    int lat;
    issue(i, v.ctrl, v.a, v.b);
    chk("alu_a_after_accept", 64'(alu_a[i]), 64'(v.a));
    chk("alu_b_after_accept", 64'(alu_b[i]), 64'(v.b));
    chk("alu_ctrl_after_accept", 64'(alu_ctrl[i]), 64'(v.ctrl));
    chk("busy_after_accept", 64'(busy[i]), 64'd1);
    wait_rsp(i, lat);
    chk("latency", 64'(lat), 64'(settle_of(i)));
    chk("rsp_result", 64'(rsp_result[i]), 64'(v.res));
    chk("rsp_flags", 64'(rsp_flags[i]), 64'(v.fl));
    chk("flags_q", 64'(flags_q[i]), 64'(v.fl));
    take(i);
    chk("rsp_valid_after_take", 64'(rsp_valid[i]), 64'd0);
  endtask

  task automatic rand_phase(input int i);
    logic [35:0] e;
    exp_q.delete();
    for (int cyc = 0; cyc < 400 + 25; cyc++) begin
      if (cyc < 400) begin
        req_valid[i] = ($urandom_range(0, 1) == 1);
        req_ctrl[i]  = 3'($urandom_range(0, 7));
        req_a[i]     = $urandom;
        req_b[i]     = ($urandom_range(0, 3) == 0) ? req_a[i] : $urandom;
        rsp_ready[i] = ($urandom_range(0, 3) != 0);
      end else begin
        req_valid[i] = 1'b0;
        rsp_ready[i] = 1'b1;
      end
      #1;
      if (rsp_valid[i]) chk("rand_flags_q", 64'(flags_q[i]), 64'(rsp_flags[i]));
      if (rsp_valid[i] && rsp_ready[i]) begin
        if (exp_q.size() == 0) begin
          chk("rand_unexpected_rsp", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          chk("rand_rsp", {28'd0, rsp_flags[i], rsp_result[i]}, 64'(e));
        end
      end
      if (req_valid[i] && req_ready[i]) exp_q.push_back(alu_ref(req_ctrl[i], req_a[i], req_b[i]));
      tick();
    end
    rsp_ready[i] = 1'b0;
    chk("rand_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_zero(input int i);
    chk("rst_rsp_valid", 64'(rsp_valid[i]), 64'd0);
    chk("rst_req_ready", 64'(req_ready[i]), 64'd0);
    chk("rst_busy", 64'(busy[i]), 64'd0);
    chk("rst_alu", {29'd0, alu_ctrl[i], alu_a[i] | alu_b[i]}, 64'd0);
    chk("rst_rsp_result", 64'(rsp_result[i]), 64'd0);
    chk("rst_rsp_flags", 64'(rsp_flags[i]), 64'd0);
    chk("rst_flags_q", 64'(flags_q[i]), 64'd0);
  endtask

  // Main sequence
  initial begin
    int lat;
    total = 0; bad = 0;
    rst_n = 1'b0; glitch_val = '0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_ctrl[i] = '0; req_a[i] = '0; req_b[i] = '0;
      rsp_ready[i] = 1'b0; glitch[i] = 1'b0;
    end
    tbl[0] = '{ALU_SLL, 32'd32, 32'd2, 32'd128, 4'b0000};
    tbl[1] = '{ALU_SRL, 32'd32, 32'd2, 32'd8, 4'b0000};
    tbl[2] = '{ALU_SUB, 32'd5, 32'd5, 32'd0, 4'b0001};
    tbl[3] = '{ALU_SUB, 32'h8000_0000, 32'd1, 32'h7fff_ffff, 4'b1000};
    tbl[4] = '{ALU_ADD, 32'hffff_ffff, 32'd1, 32'd0, 4'b0101};
    tbl[5] = '{ALU_ADD, 32'h7fff_ffff, 32'd1, 32'h8000_0000, 4'b1010};
    tbl[6] = '{ALU_AND, 32'h0000_f0f0, 32'h0000_ff00, 32'h0000_f000, 4'b0000};
    tbl[7] = '{ALU_SLT, 32'hffff_ffff, 32'd1, 32'd1, 4'b0000};
    tbl[8] = '{ALU_XOR, 32'd5, 32'd5, 32'd0, 4'b0001};

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) chk_zero(i);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // Directed vectors on both settle depths
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 9; k++) run_vec(i, tbl[k]);

    // Stalled response, then response and new request on one edge
    for (int i = 0; i < 2; i++) begin
      issue(i, ALU_SUB, 32'd5, 32'd5);
      wait_rsp(i, lat);
      req_valid[i] = 1'b1; req_ctrl[i] = ALU_ADD; req_a[i] = 32'd1; req_b[i] = 32'd2;
      rsp_ready[i] = 1'b0;
      for (int n = 0; n < 5; n++) begin
        tick();
        chk("stall_rsp_valid", 64'(rsp_valid[i]), 64'd1);
        chk("stall_rsp", {28'd0, rsp_flags[i], rsp_result[i]}, {28'd0, 4'b0001, 32'd0});
        chk("stall_req_ready", 64'(req_ready[i]), 64'd0);
        chk("stall_alu_a", 64'(alu_a[i]), 64'd5);
      end
      rsp_ready[i] = 1'b1;
      #1;
      chk("chain_req_ready", 64'(req_ready[i]), 64'd1);
      tick();
      req_valid[i] = 1'b0; rsp_ready[i] = 1'b0;
      chk("chain_no_stale_rsp", 64'(rsp_valid[i]), 64'd0);
      chk("chain_alu_a", 64'(alu_a[i]), 64'd1);
      wait_rsp(i, lat);
      chk("chain_latency", 64'(lat), 64'(settle_of(i)));
      chk("chain_rsp", {28'd0, rsp_flags[i], rsp_result[i]}, 64'd3);
      take(i);
    end

    // Settle window on the 3-cycle instance: alu_out disturbed until the sample edge
    issue(1, ALU_ADD, 32'd10, 32'd20);
    glitch_val = 32'hdead_beef; glitch[1] = 1'b1;
    tick(); chk("settle_k1_valid", 64'(rsp_valid[1]), 64'd0);
    tick(); chk("settle_k2_valid", 64'(rsp_valid[1]), 64'd0);
    glitch[1] = 1'b0;
    tick(); chk("settle_k3_valid", 64'(rsp_valid[1]), 64'd1);
    chk("settle_k3_result", 64'(rsp_result[1]), 64'd30);
    take(1);

    // Random traffic against the queue model
    rand_phase(0);
    rand_phase(1);

    // Reset while one instance waits in RESP and the other in SETTLE
    issue(0, ALU_SUB, 32'd5, 32'd5);
    issue(1, ALU_SUB, 32'd5, 32'd5);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) chk_zero(i);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    tick();
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 2; i++) begin
        chk("post_rst_valid", 64'(rsp_valid[i]), 64'd0);
        chk("post_rst_flags_q", 64'(flags_q[i]), 64'd0);
      end
      tick();
    end
    for (int i = 0; i < 2; i++) run_vec(i, tbl[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
